// File: rtl/fp_mul_pkg.sv
// Shared types, constants and field helpers for the sequential FP32 multiplier.
package fp_mul_pkg;

  localparam int MAN_W = 24;   // significand width including the hidden bit
  localparam int EXP_W = 8;    // exponent field width
  localparam int BIAS  = 127;  // exponent bias
  localparam int CNT_W = 5;    // iteration counter width, 2**CNT_W > MAN_W

  localparam logic [EXP_W-1:0] EXP_ALL1 = 8'hFF;
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MULT  = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-2:0] frac;
  } fp_fields_t;

  // Split a single-precision word into sign, exponent and fraction fields.
  function automatic fp_fields_t fp_split(input logic [31:0] v);
    fp_fields_t f;
    f.sign = v[31];
    f.exp  = v[30:23];
    f.frac = v[22:0];
    return f;
  endfunction

endpackage

// File: rtl/fp_shift_add_core.sv
// Radix-2 shift-add significand multiplier: one partial product per step.
// The multiplier is held in the low half of the 48-bit accumulator and
// shifts out of bit 0 as the product shifts in from the top.
module fp_shift_add_core #(
  parameter int MAN_W = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [MAN_W-1:0] i_mcand,
  input  logic [MAN_W-1:0] i_mplier,
  output logic [MAN_W:0]   o_prod_hi,
  output logic             o_last
);

  logic [MAN_W-1:0]   r_mcand;
  logic [2*MAN_W-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [MAN_W-1:0]   w_addend;
  logic [MAN_W:0]     w_sum;

  assign w_addend  = r_acc[0] ? r_mcand : {MAN_W{1'b0}};
  assign w_sum     = {1'b0, r_acc[2*MAN_W-1:MAN_W]} + {1'b0, w_addend};
  // Only bits 47..23 of the product matter after truncating normalisation.
  assign o_prod_hi = r_acc[2*MAN_W-1:MAN_W-1];
  assign o_last    = (r_cnt == CNT_W'(MAN_W - 1));

  // Load operands, or add the current partial product and shift right.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= {MAN_W{1'b0}};
      r_acc   <= {(2*MAN_W){1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_mcand <= i_mcand;
      r_acc   <= {{MAN_W{1'b0}}, i_mplier};
      r_cnt   <= {CNT_W{1'b0}};
    end else if (i_step) begin
      r_acc   <= {w_sum, r_acc[MAN_W-1:1]};
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fp_mul_seq_ctrl.sv
// Sequencer for FP32 multiply: classify, iterate shift-add, normalise, pack.
module fp_mul_seq_ctrl
  import fp_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        flag_inf,
  output logic        flag_nan,
  output logic        flag_zero
);

  state_t           r_state, w_next;
  logic [31:0]      r_a, r_b, r_result, w_result;
  logic             r_flag_inf, r_flag_nan, r_flag_zero;
  logic             w_flag_inf, w_flag_nan, w_flag_zero;
  logic             r_done, r_busy;
  fp_fields_t       w_fa, w_fb;
  logic             w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  logic             w_sign, w_is_nan, w_is_inf, w_is_zero, w_special;
  logic [31:0]      w_special_res, w_norm_res;
  logic             w_norm_inf, w_norm_zero;
  logic             w_load, w_step, w_last, w_accept;
  logic [MAN_W:0]   w_prod_hi;
  logic [MAN_W-2:0] w_norm_frac;
  logic signed [EXP_W+1:0] w_exp_n;

  assign w_fa     = fp_split(r_a);
  assign w_fb     = fp_split(r_b);
  // Denormals share exponent 0 and are flushed to zero.
  assign w_a_zero = (w_fa.exp == 8'h00);
  assign w_b_zero = (w_fb.exp == 8'h00);
  assign w_a_inf  = (w_fa.exp == EXP_ALL1) && (w_fa.frac == 23'd0);
  assign w_b_inf  = (w_fb.exp == EXP_ALL1) && (w_fb.frac == 23'd0);
  assign w_a_nan  = (w_fa.exp == EXP_ALL1) && (w_fa.frac != 23'd0);
  assign w_b_nan  = (w_fb.exp == EXP_ALL1) && (w_fb.frac != 23'd0);
  assign w_sign   = w_fa.sign ^ w_fb.sign;
  assign w_is_nan  = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
  assign w_is_inf  = w_a_inf | w_b_inf;
  assign w_is_zero = w_a_zero | w_b_zero;
  assign w_special = w_is_nan | w_is_inf | w_is_zero;
  assign w_accept  = (r_state == IDLE) && start;

  fp_shift_add_core #(
    .MAN_W (MAN_W),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_mcand   ({1'b1, w_fa.frac}),
    .i_mplier  ({1'b1, w_fb.frac}),
    .o_prod_hi (w_prod_hi),
    .o_last    (w_last)
  );

  // Product bit 47 set means the significand product lies in [2,4).
  assign w_exp_n = $signed({2'b00, w_fa.exp}) + $signed({2'b00, w_fb.exp})
                 - $signed(10'(BIAS)) + $signed({9'd0, w_prod_hi[MAN_W]});
  assign w_norm_frac = w_prod_hi[MAN_W] ? w_prod_hi[MAN_W-1:1] : w_prod_hi[MAN_W-2:0];

  // Pick the special-case word by priority NaN > Inf > zero.
  always_comb begin
    w_special_res = {w_sign, 31'd0};
    if (w_is_nan) begin
      w_special_res = QNAN;
    end else if (w_is_inf) begin
      w_special_res = {w_sign, EXP_ALL1, 23'd0};
    end else begin
      w_special_res = {w_sign, 31'd0};
    end
  end

  // Pack the normalised product, saturating to Inf or flushing to zero.
  always_comb begin
    w_norm_inf  = 1'b0;
    w_norm_zero = 1'b0;
    w_norm_res  = {w_sign, w_exp_n[EXP_W-1:0], w_norm_frac};
    if (w_exp_n >= 10'sd255) begin
      w_norm_inf = 1'b1;
      w_norm_res = {w_sign, EXP_ALL1, 23'd0};
    end else if (w_exp_n <= 10'sd0) begin
      w_norm_zero = 1'b1;
      w_norm_res  = {w_sign, 31'd0};
    end else begin
      w_norm_res = {w_sign, w_exp_n[EXP_W-1:0], w_norm_frac};
    end
  end

  // Next-state, core control and result/flag update decisions.
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_result    = r_result;
    w_flag_inf  = r_flag_inf;
    w_flag_nan  = r_flag_nan;
    w_flag_zero = r_flag_zero;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next      = CHECK;
          w_flag_inf  = 1'b0;
          w_flag_nan  = 1'b0;
          w_flag_zero = 1'b0;
        end else begin
          w_next = IDLE;
        end
      end
      CHECK: begin
        if (w_special) begin
          w_next      = DONE;
          w_result    = w_special_res;
          w_flag_nan  = w_is_nan;
          w_flag_inf  = ~w_is_nan & w_is_inf;
          w_flag_zero = ~w_is_nan & ~w_is_inf & w_is_zero;
        end else begin
          w_load = 1'b1;
          w_next = MULT;
        end
      end
      MULT: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next = NORM;
        end else begin
          w_next = MULT;
        end
      end
      NORM: begin
        w_next      = DONE;
        w_result    = w_norm_res;
        w_flag_nan  = 1'b0;
        w_flag_inf  = w_norm_inf;
        w_flag_zero = w_norm_zero;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, operand latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_result    <= 32'd0;
      r_flag_inf  <= 1'b0;
      r_flag_nan  <= 1'b0;
      r_flag_zero <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      if (w_accept) begin
        r_a <= a;
        r_b <= b;
      end
      r_result    <= w_result;
      r_flag_inf  <= w_flag_inf;
      r_flag_nan  <= w_flag_nan;
      r_flag_zero <= w_flag_zero;
      r_done      <= (w_next == DONE);
      r_busy      <= (w_next != IDLE);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign flag_inf  = r_flag_inf;
  assign flag_nan  = r_flag_nan;
  assign flag_zero = r_flag_zero;

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Self-checking bench for fp_mul_seq_ctrl against an arithmetic reference model.
module tb_fp_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done, flag_inf, flag_nan, flag_zero;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  fp_mul_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .flag_inf(flag_inf), .flag_nan(flag_nan), .flag_zero(flag_zero)
  );

  always #5 clk = ~clk;

  // Reference: classify, multiply significands as integers, truncate.
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [2:0] fl,
                                  output int lat);
    logic s, zx, zy, ix, iy, nx, ny;
    int ex, ey, e;
    longint unsigned mx, my, p, m;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = longint'(x[22:0]);
    my = longint'(y[22:0]);
    zx = (ex == 0);   zy = (ey == 0);
    ix = (ex == 255) && (mx == 0);  iy = (ey == 255) && (my == 0);
    nx = (ex == 255) && (mx != 0);  ny = (ey == 255) && (my != 0);
    lat = 2;
    fl  = 3'b000;
    if (nx || ny || (ix && zy) || (iy && zx)) begin
      r = 32'h7FC00000; fl = 3'b100;
    end else if (ix || iy) begin
      r = {s, 8'hFF, 23'd0}; fl = 3'b010;
    end else if (zx || zy) begin
      r = {s, 31'd0}; fl = 3'b001;
    end else begin
      lat = 27;
      p = (mx + 64'd8388608) * (my + 64'd8388608);
      e = ex + ey - 127;
      if (p >= 64'd140737488355328) begin
        e = e + 1;
        m = (p / 64'd16777216) % 64'd8388608;
      end else begin
        m = (p / 64'd8388608) % 64'd8388608;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0}; fl = 3'b010;
      end else if (e <= 0) begin
        r = {s, 31'd0}; fl = 3'b001;
      end else begin
        r = {s, 8'(e), 23'(m)};
      end
    end
  endfunction

  function automatic logic [31:0] rand_any();
    logic [31:0] v;
    int kind;
    v = $urandom;
    kind = $urandom_range(0, 9);
    if (kind == 0) v[30:23] = 8'h00;
    else if (kind == 1) v[30:0] = {8'hFF, 23'd0};
    else if (kind == 2) v[30:23] = 8'hFF;
    return v;
  endfunction

  function automatic logic [31:0] rand_norm();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'($urandom_range(1, 254));
    return v;
  endfunction

  // Issue one operation from a negedge; report latency, result, flags, busy at done.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, output int lat,
                       output logic [31:0] r, output logic [2:0] fl, output logic bsy);
    a = x; b = y; start = 1'b1;
    lat = -1; r = 32'd0; fl = 3'b000; bsy = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin
        lat = k; r = result; fl = {flag_nan, flag_inf, flag_zero}; bsy = busy;
        break;
      end
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    @(negedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (result !== 32'd0) begin n_errors++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++;
    if ({flag_nan, flag_inf, flag_zero} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags: got %b want 000", {flag_nan, flag_inf, flag_zero});
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[6] = '{32'h40000000, 32'h3FC00000, 32'h7F800000, 32'hFF800000, 32'h7F000000, 32'h00800000};
    logic [31:0] vb[6] = '{32'h40400000, 32'h3FC00000, 32'h00000000, 32'h40000000, 32'h7F000000, 32'h00800000};
    logic [31:0] vr[6] = '{32'h40C00000, 32'h40100000, 32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000000};
    logic [2:0]  vf[6] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b010, 3'b001};
    int          vl[6] = '{27, 27, 2, 2, 27, 27};
    int lat; logic [31:0] r; logic [2:0] fl; logic bsy;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], lat, r, fl, bsy);
      n_checks++; if (r !== vr[i]) begin n_errors++; $display("FAIL dir%0d_result: got %h want %h", i, r, vr[i]); end
      n_checks++; if (fl !== vf[i]) begin n_errors++; $display("FAIL dir%0d_flags: got %b want %b", i, fl, vf[i]); end
      n_checks++; if (lat != vl[i]) begin n_errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, vl[i]); end
      n_checks++; if (bsy !== 1'b1) begin n_errors++; $display("FAIL dir%0d_busy_at_done: got %b want 1", i, bsy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL dir%0d_done_width: got %b want 0", i, done); end
    end
  endtask

  task automatic test_random();
    int lat, elat; logic [31:0] r, er, x, y; logic [2:0] fl, efl; logic bsy;
    for (int i = 0; i < 48; i++) begin
      x = rand_any(); y = rand_any();
      ref_mul(x, y, er, efl, elat);
      do_op(x, y, lat, r, fl, bsy);
      n_checks++; if (r !== er) begin n_errors++; $display("FAIL rnd_result %h*%h: got %h want %h", x, y, r, er); end
      n_checks++; if (fl !== efl) begin n_errors++; $display("FAIL rnd_flags %h*%h: got %b want %b", x, y, fl, efl); end
      n_checks++; if (lat != elat) begin n_errors++; $display("FAIL rnd_latency %h*%h: got %0d want %0d", x, y, lat, elat); end
    end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0; int first_k = -1; logic [31:0] r = 32'd0;
    a = 32'h40000000; b = 32'h40400000; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1 || k == 11) start = 1'b0;
      if (k == 10) begin a = 32'h3FC00000; b = 32'h3FC00000; start = 1'b1; end
      if (done) begin
        ndone++;
        if (first_k < 0) begin first_k = k; r = result; end
        a = 32'h7F800000; b = 32'h00000000; start = 1'b1;
      end else if (first_k > 0 && k == first_k + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_checks++; if (first_k != 27) begin n_errors++; $display("FAIL ign_latency: got %0d want 27", first_k); end
    n_checks++; if (r !== 32'h40C00000) begin n_errors++; $display("FAIL ign_result: got %h want 40c00000", r); end
    n_checks++; if (ndone != 1) begin n_errors++; $display("FAIL ign_done_count: got %0d want 1", ndone); end
    n_checks++; if (result !== 32'h40C00000) begin n_errors++; $display("FAIL ign_result_held: got %h want 40c00000", result); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ign_not_queued_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0; int lat; logic [31:0] r; logic [2:0] fl; logic bsy;
    a = 32'h40000000; b = 32'h40400000; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) ndone++;
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_checks++; if (result !== 32'd0) begin n_errors++; $display("FAIL rstmid_result: got %h want 0", result); end
    for (int k = 0; k < 35; k++) begin
      @(posedge clk); @(negedge clk);
      if (done) ndone++;
    end
    n_checks++; if (ndone != 0) begin n_errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", ndone); end
    do_op(32'h40000000, 32'h40400000, lat, r, fl, bsy);
    n_checks++; if (r !== 32'h40C00000) begin n_errors++; $display("FAIL rstmid_after_result: got %h want 40c00000", r); end
    n_checks++; if (lat != 27) begin n_errors++; $display("FAIL rstmid_after_latency: got %0d want 27", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, elat; logic [31:0] r, er, x, y; logic [2:0] fl, efl; logic bsy;
    for (int i = 0; i < 5; i++) begin
      x = rand_norm(); y = rand_norm();
      ref_mul(x, y, er, efl, elat);
      do_op(x, y, lat, r, fl, bsy);
      n_checks++; if (r !== er) begin n_errors++; $display("FAIL b2b_result %h*%h: got %h want %h", x, y, r, er); end
      n_checks++; if (lat != elat) begin n_errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, elat); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq_ctrl.md
Name: fp_mul_seq_ctrl

Overview:
Multi-cycle sequencer for IEEE-754 single-precision multiplication using one shift-add step per cycle.
- Accepts an operand pair on a start pulse.
- Classifies both operands (zero/Inf/NaN) and short-circuits special cases.
- Otherwise runs a 24-iteration mantissa shift-add, then normalises, packs and presents the result with a one-cycle done pulse.
- Sits between the operand source and the result consumer of the MUL/SHIFT_ADD path.

Parameters:
MAN_W, 24, significand width including hidden bit (iteration count)
EXP_W, 8, exponent field width
BIAS, 127, exponent bias
CNT_W, 5, iteration counter width (must satisfy 2^CNT_W > MAN_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
a  input  32  operand A, IEEE-754 single
b  input  32  operand B, IEEE-754 single
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, result valid
result  output  32  product; held from done until the next accepted start
flag_inf  output  1  result is ±Inf; valid with result
flag_nan  output  1  result is NaN; valid with result
flag_zero  output  1  result is ±0; valid with result

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous and active-high (rst). On reset: state=IDLE, busy=0, done=0, result=0, all flags=0, counter=0, accumulator=0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- FSM states: IDLE, CHECK, MULT, NORM, DONE.
  - IDLE: start=1 latches a and b. Next state is CHECK.
  - CHECK: classifies both operands. Exponent field 0 is zero; denormals are flushed to zero. Exponent 0xFF with fraction 0 is Inf; exponent 0xFF with fraction != 0 is NaN.
    - Special cases go directly to DONE. Otherwise load mcand={1,fracA}, mplier={1,fracB}, acc=0, cnt=0, and go to MULT.
  - MULT: one step per cycle. If mplier[0]=1, add mcand to the upper part of a 48-bit accumulator; then shift right (standard shift-add). After cnt reaches MAN_W-1 (24 cycles), go to NORM.
  - NORM:
    - If P[47]=1: frac=P[46:24], exp=ea+eb-BIAS+1. Else: frac=P[45:23], exp=ea+eb-BIAS.
    - Rounding is truncation (round toward zero).
    - Compute exp with signed EXP_W+2 bits. exp>=255 gives ±Inf with flag_inf. exp<=0 gives ±0 with flag_zero. Next state is DONE.
  - DONE: done=1 for exactly one cycle, result and flags driven. Next state is IDLE.
- Special-case priority:
  1. Either operand NaN, or Inf×0 → 0x7FC00000 (canonical qNaN), flag_nan=1.
  2. Otherwise either operand Inf → {sA^sB, 0xFF, 0}, flag_inf=1.
  3. Otherwise either operand zero → {sA^sB, 31'b0}, flag_zero=1.
- Sign: always sA^sB, except for NaN.
- Latency (start sampled at edge t):
  - Special case: done at cycle t+2.
  - Normal case: MULT covers t+2..t+25, NORM is t+26, done at t+27.
  - The next start is accepted at t+28 or later (normal case).
- start while busy=1, including during DONE, is ignored and not queued.
- Flags are mutually exclusive. Each is cleared when the next start is accepted.

Decomposition:
- Package fp_mul_pkg holds:
  - state enum {IDLE, CHECK, MULT, NORM, DONE};
  - constants EXP_ALL1=8'hFF, QNAN=32'h7FC00000, BIAS;
  - a field-extract helper (sign/exp/frac).
- One natural sub-module: fp_shift_add_core. It contains the 48-bit accumulator, multiplicand/multiplier registers and the iteration counter, with a load/step/last interface.
- FSM, classification, normalise and pack stay in fp_mul_seq_ctrl.

Test Plan:
- a=0x40000000, b=0x40400000, start at t → done at t+27, result=0x40C00000, all flags 0.
- a=b=0x3FC00000 (1.5×1.5) → result=0x40100000, which exercises the P[47]=1 normalise path.
- a=0x7F800000, b=0x00000000 → done at t+2, result=0x7FC00000, flag_nan=1. Also a=0xFF800000, b=0x40000000 → 0xFF800000, flag_inf=1.
- a=b=0x7F000000 → 0x7F800000, flag_inf=1 (overflow). a=b=0x00800000 → 0x00000000, flag_zero=1 (underflow).
- Assert start with different operands during MULT → ignored; the first result is unchanged and done pulses exactly once.
- Assert rst at t+10 of a normal operation → busy=0, result=0 the next cycle, no done pulse. A following 2.0×3.0 yields 0x40C00000.
